// File: rtl/systola_plm_loader_if.sv
// systola_plm_loader_if: ESP DMA read request and read channel bundle.
// The master side is the loader that issues requests and sinks data words.
// The slave side is the DMA engine that accepts requests and sources data words.
interface systola_plm_loader_if;
    logic        dma_read_ctrl_valid;
    logic        dma_read_ctrl_ready;
    logic [31:0] dma_read_ctrl_data_index;
    logic [31:0] dma_read_ctrl_data_length;
    logic [2:0]  dma_read_ctrl_data_size;
    logic        dma_read_chnl_valid;
    logic        dma_read_chnl_ready;
    logic [31:0] dma_read_chnl_data;

    modport master (
        output dma_read_ctrl_valid,
        input  dma_read_ctrl_ready,
        output dma_read_ctrl_data_index,
        output dma_read_ctrl_data_length,
        output dma_read_ctrl_data_size,
        input  dma_read_chnl_valid,
        output dma_read_chnl_ready,
        input  dma_read_chnl_data
    );

    modport slave (
        input  dma_read_ctrl_valid,
        output dma_read_ctrl_ready,
        input  dma_read_ctrl_data_index,
        input  dma_read_ctrl_data_length,
        input  dma_read_ctrl_data_size,
        output dma_read_chnl_valid,
        input  dma_read_chnl_ready,
        output dma_read_chnl_data
    );
endinterface

// File: rtl/systola_plm_loader.sv
// systola_plm_loader: DMA input stage ahead of the systolic GEMM datapath.
// Fetches A (8xN) followed by B (Nx8) in one read burst and scatters the
// bytes into PLM port 0: A from address 0, B from B_BASE.
module systola_plm_loader #(
    parameter int MAX_DEPTH = 64,
    parameter int B_BASE    = 512
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 start,
    input  logic [31:0]          depth,
    systola_plm_loader_if.master dma,
    output logic [10:0]          plm_a0,
    output logic [7:0]           plm_d0,
    output logic                 plm_ce0,
    output logic                 plm_we0,
    output logic [7:0]           plm_wem0,
    output logic                 busy,
    output logic                 done,
    output logic                 err
);
    localparam int N_W = $clog2(MAX_DEPTH + 1);
    localparam int K_W = $clog2(16 * MAX_DEPTH);
    localparam int A_W = 11;

    typedef enum logic [2:0] {IDLE, REQ, RECV, UNPACK, DONE} state_t;

    state_t         state;
    state_t         state_next;
    logic [N_W-1:0] n_reg;
    logic [K_W-1:0] byte_idx;
    logic [31:0]    hold_reg;
    logic           err_reg;

    logic           start_take;
    logic           depth_ok;
    logic           word_in;
    logic           last_byte;
    logic [A_W-1:0] k_ext;
    logic [A_W-1:0] a_bytes;
    logic [A_W-1:0] k_last;
    logic [A_W-1:0] byte_addr;
    logic [7:0]     cur_byte;

    // A start is only honoured when no load is in flight.
    assign start_take = start && (state == IDLE || state == DONE);
    assign depth_ok   = (depth != 32'd0) && (depth <= 32'(MAX_DEPTH));
    assign word_in    = (state == RECV) && dma.dma_read_chnl_valid;

    // Byte k lands at k inside A (first 8N bytes), then at B_BASE+(k-8N).
    assign k_ext     = A_W'(byte_idx);
    assign a_bytes   = A_W'({n_reg, 3'b000});
    assign k_last    = A_W'({n_reg, 4'b0000}) - A_W'(1);
    assign last_byte = (k_ext == k_last);
    assign byte_addr = (k_ext < a_bytes) ? k_ext : (A_W'(B_BASE) + k_ext - a_bytes);
    assign cur_byte  = 8'(hold_reg >> {byte_idx[1:0], 3'b000});

    // State register; reset drops any load in progress back to IDLE.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    // Latch N and the error flag on an accepted start, capture words, and step the byte index.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            n_reg    <= '0;
            byte_idx <= '0;
            hold_reg <= '0;
            err_reg  <= 1'b0;
        end else begin
            if (start_take) begin
                n_reg    <= depth_ok ? depth[N_W-1:0] : '0;
                err_reg  <= !depth_ok;
                byte_idx <= '0;
            end else if (state == UNPACK) begin
                byte_idx <= byte_idx + K_W'(1);
            end
            if (word_in) begin
                hold_reg <= dma.dma_read_chnl_data;
            end
        end
    end

    // Next-state logic: one request, then alternate receive and 4-cycle unpack until the last byte.
    always_comb begin
        state_next = state;
        case (state)
            IDLE, DONE: begin
                if (start) begin
                    state_next = depth_ok ? REQ : DONE;
                end
            end
            REQ: begin
                if (dma.dma_read_ctrl_ready) begin
                    state_next = RECV;
                end
            end
            RECV: begin
                if (dma.dma_read_chnl_valid) begin
                    state_next = UNPACK;
                end
            end
            UNPACK: begin
                if (byte_idx[1:0] == 2'd3) begin
                    state_next = last_byte ? DONE : RECV;
                end
            end
            default: state_next = IDLE;
        endcase
    end

    // Moore outputs: every bus stays zero outside the state that owns it.
    always_comb begin
        dma.dma_read_ctrl_valid       = 1'b0;
        dma.dma_read_ctrl_data_index  = 32'd0;
        dma.dma_read_ctrl_data_length = 32'd0;
        dma.dma_read_ctrl_data_size   = 3'b000;
        dma.dma_read_chnl_ready       = 1'b0;
        plm_a0                        = '0;
        plm_d0                        = 8'd0;
        plm_ce0                       = 1'b0;
        plm_we0                       = 1'b0;
        plm_wem0                      = 8'd0;
        busy                          = 1'b0;
        done                          = 1'b0;
        err                           = err_reg;
        case (state)
            REQ: begin
                busy                          = 1'b1;
                dma.dma_read_ctrl_valid       = 1'b1;
                dma.dma_read_ctrl_data_length = 32'({n_reg, 2'b00});
                dma.dma_read_ctrl_data_size   = 3'b010;
            end
            RECV: begin
                busy                    = 1'b1;
                dma.dma_read_chnl_ready = 1'b1;
            end
            UNPACK: begin
                busy     = 1'b1;
                plm_a0   = byte_addr;
                plm_d0   = cur_byte;
                plm_ce0  = 1'b1;
                plm_we0  = 1'b1;
                plm_wem0 = 8'hFF;
            end
            DONE: begin
                done = 1'b1;
            end
            default: ;
        endcase
    end
endmodule

// File: tb/tb_systola_plm_loader.sv
// tb_systola_plm_loader: directed scenarios with randomized data and DMA
// stalls, compared against a byte-stream model of the PLM image.
`timescale 1ns/1ps
module tb_systola_plm_loader;
    localparam int MAX_DEPTH = 64;
    localparam int B_BASE    = 512;

    logic        clk;
    logic        rst;
    logic        start;
    logic [31:0] depth;
    logic [10:0] plm_a0;
    logic [7:0]  plm_d0;
    logic        plm_ce0;
    logic        plm_we0;
    logic [7:0]  plm_wem0;
    logic        busy;
    logic        done;
    logic        err;

    systola_plm_loader_if dma_if ();

    systola_plm_loader #(.MAX_DEPTH(MAX_DEPTH), .B_BASE(B_BASE)) dut (
        .clk      (clk),
        .rst      (rst),
        .start    (start),
        .depth    (depth),
        .dma      (dma_if),
        .plm_a0   (plm_a0),
        .plm_d0   (plm_d0),
        .plm_ce0  (plm_ce0),
        .plm_we0  (plm_we0),
        .plm_wem0 (plm_wem0),
        .busy     (busy),
        .done     (done),
        .err      (err)
    );

    // 10 ns clock
    always #5 clk = ~clk;

    int checks;
    int errors;

    logic [31:0] words[$];
    logic [7:0]  obsMem[2048];
    bit          obsWritten[2048];
    logic [7:0]  expMem[2048];
    bit          expWritten[2048];

    int          curN;
    int          accepted;
    int          writeCount;
    int          reqCount;
    int          ctrlCycles;
    int          ctrlValidSeen;
    int          payloadBad;
    int          readyBad;
    int          earlyRecv;
    int          wemBad;
    int          doneRises;
    int          cycles;
    bit          prevDone;
    bit          aborted;
    bit          poked;
    logic [31:0] firstLength;
    logic [10:0] lastAddr;

    task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
        checks++;
        assert (observed === expected) else begin
            errors++;
            $error("[TB] FAIL %s: observed 0x%0h expected 0x%0h", tag, observed, expected);
        end
    endtask

    // Reference image: the word stream is a byte stream; its first 8N bytes are A, the rest B.
    function automatic int countMemBad(input int n);
        int bad;
        logic [31:0] w;
        int addr;
        bad = 0;
        for (int a = 0; a < 2048; a++) begin
            expWritten[a] = 0;
            expMem[a]     = 8'h00;
        end
        for (int q = 0; q < 16 * n; q++) begin
            w    = words[q / 4];
            addr = (q < 8 * n) ? q : B_BASE + (q - 8 * n);
            expMem[addr]     = 8'(w >> (8 * (q % 4)));
            expWritten[addr] = 1;
        end
        for (int a = 0; a < 2048; a++) begin
            if (expWritten[a] != obsWritten[a]) bad++;
            else if (expWritten[a] && (expMem[a] !== obsMem[a])) bad++;
        end
        return bad;
    endfunction

    // One cycle of the DMA/PLM environment: observe at the falling edge, then drive inputs.
    task automatic sampleCycle(input int ctrlDelay, input int validPct, input int abortWord, input bit pokeStart);
        @(negedge clk);
        start = 1'b0;
        cycles++;
        if (done && !prevDone) doneRises++;
        prevDone = done;
        if (plm_ce0 && plm_we0) begin
            obsWritten[plm_a0] = 1;
            obsMem[plm_a0]     = plm_d0;
            writeCount++;
            lastAddr = plm_a0;
            if (plm_wem0 !== 8'hFF) wemBad++;
        end
        if (dma_if.dma_read_ctrl_valid) begin
            ctrlValidSeen++;
            ctrlCycles++;
            if (ctrlCycles == 1) firstLength = dma_if.dma_read_ctrl_data_length;
            if (dma_if.dma_read_ctrl_data_index !== 32'd0 ||
                dma_if.dma_read_ctrl_data_length !== 32'(4 * curN) ||
                dma_if.dma_read_ctrl_data_size !== 3'b010) payloadBad++;
            dma_if.dma_read_ctrl_ready = (ctrlCycles > ctrlDelay);
            if (dma_if.dma_read_ctrl_ready) reqCount++;
        end else begin
            dma_if.dma_read_ctrl_ready = 1'b0;
        end
        if (dma_if.dma_read_chnl_ready) begin
            if (plm_ce0 || dma_if.dma_read_ctrl_valid || !busy) readyBad++;
            if (reqCount == 0) earlyRecv++;
            if (pokeStart && !poked) begin
                start = 1'b1;
                depth = 32'd5;
                poked = 1;
            end
        end
        dma_if.dma_read_chnl_valid = ($urandom_range(0, 99) < validPct);
        dma_if.dma_read_chnl_data  = (accepted < words.size()) ? words[accepted] : 32'hDEAD_BEEF;
        if (dma_if.dma_read_chnl_ready && dma_if.dma_read_chnl_valid) accepted++;
        if (abortWord > 0 && accepted == abortWord && plm_ce0 && !aborted) begin
            #2 rst = 1'b0;
            #1;
            aborted = 1;
            checkOutput("abort_busy_done_err", {busy, done, err}, 32'd0);
            checkOutput("abort_plm_port", {plm_ce0, plm_we0, plm_wem0, plm_a0, plm_d0}, 32'd0);
            checkOutput("abort_dma_ctrl", {dma_if.dma_read_ctrl_valid, dma_if.dma_read_chnl_ready,
                                          dma_if.dma_read_ctrl_data_size}, 32'd0);
            checkOutput("abort_length", dma_if.dma_read_ctrl_data_length, 32'd0);
        end
    endtask

    // Start a load with depth d and run it until done, an abort, or the cycle budget runs out.
    task automatic applyStimulus(input int d, input int validPct, input int ctrlDelay,
                                 input int abortWord, input bit pokeStart, input bit directed);
        logic [31:0] w;
        curN = (d >= 1 && d <= MAX_DEPTH) ? d : 0;
        words.delete();
        for (int i = 0; i < 4 * curN; i++) begin
            if (directed) w = {8'(4 * i + 3), 8'(4 * i + 2), 8'(4 * i + 1), 8'(4 * i)};
            else          w = $urandom;
            words.push_back(w);
        end
        for (int a = 0; a < 2048; a++) begin
            obsWritten[a] = 0;
            obsMem[a]     = 8'h00;
        end
        accepted = 0; writeCount = 0; reqCount = 0; ctrlCycles = 0; ctrlValidSeen = 0;
        payloadBad = 0; readyBad = 0; earlyRecv = 0; wemBad = 0; doneRises = 0; cycles = 0;
        aborted = 0; poked = 0; firstLength = 32'hFFFF_FFFF; lastAddr = '0;
        @(negedge clk);
        prevDone = done;
        start    = 1'b1;
        depth    = 32'(d);
        dma_if.dma_read_ctrl_ready = 1'b0;
        dma_if.dma_read_chnl_valid = 1'b0;
        while (!aborted && cycles < 20000) begin
            sampleCycle(ctrlDelay, validPct, abortWord, pokeStart);
            if (prevDone) break;
        end
        checkOutput("load_terminates", {31'd0, (cycles >= 20000)}, 32'd0);
        if (!aborted) begin
            for (int t = 0; t < 4; t++) sampleCycle(ctrlDelay, validPct, 0, 1'b0);
        end
    endtask

    initial begin
        clk = 1'b0; rst = 1'b1; start = 1'b0; depth = 32'd0;
        checks = 0; errors = 0; curN = 0; prevDone = 0;
        dma_if.dma_read_ctrl_ready = 1'b0;
        dma_if.dma_read_chnl_valid = 1'b0;
        dma_if.dma_read_chnl_data  = 32'd0;

        $display("[TB] reset state");
        #3 rst = 1'b0;
        #1;
        checkOutput("reset_busy_done_err", {busy, done, err}, 32'd0);
        checkOutput("reset_plm_port", {plm_ce0, plm_we0, plm_wem0, plm_a0, plm_d0}, 32'd0);
        checkOutput("reset_dma_valid_ready", {dma_if.dma_read_ctrl_valid, dma_if.dma_read_chnl_ready}, 32'd0);
        checkOutput("reset_length", dma_if.dma_read_ctrl_data_length, 32'd0);
        @(negedge clk);
        rst = 1'b1;

        $display("[TB] N=1 directed words");
        applyStimulus(1, 100, 0, 0, 1'b0, 1'b1);
        checkOutput("n1_length", firstLength, 32'd4);
        checkOutput("n1_payload_bad", payloadBad, 32'd0);
        checkOutput("n1_words", accepted, 32'd4);
        checkOutput("n1_writes", writeCount, 32'd16);
        checkOutput("n1_a_byte7", {24'd0, obsMem[7]}, 32'h07);
        checkOutput("n1_b_byte512", {24'd0, obsMem[512]}, 32'h08);
        checkOutput("n1_b_byte519", {24'd0, obsMem[519]}, 32'h0F);
        checkOutput("n1_mem_bad", countMemBad(1), 32'd0);
        checkOutput("n1_done_err_busy", {done, err, busy}, 32'b100);

        $display("[TB] N=64 random data, 50 percent channel valid");
        applyStimulus(64, 50, 0, 0, 1'b0, 1'b0);
        checkOutput("n64_words", accepted, 32'd256);
        checkOutput("n64_writes", writeCount, 32'd1024);
        checkOutput("n64_last_addr", {21'd0, lastAddr}, 32'd1023);
        checkOutput("n64_ready_outside_recv", readyBad, 32'd0);
        checkOutput("n64_wem_bad", wemBad, 32'd0);
        checkOutput("n64_mem_bad", countMemBad(64), 32'd0);
        checkOutput("n64_done_err", {done, err}, 32'b10);

        $display("[TB] illegal depths");
        applyStimulus(0, 100, 0, 0, 1'b0, 1'b0);
        checkOutput("d0_latency", cycles, 32'd5);
        checkOutput("d0_done_err_busy", {done, err, busy}, 32'b110);
        checkOutput("d0_no_request", ctrlValidSeen, 32'd0);
        applyStimulus(65, 100, 0, 0, 1'b0, 1'b0);
        checkOutput("d65_done_err_busy", {done, err, busy}, 32'b110);
        checkOutput("d65_no_request", ctrlValidSeen, 32'd0);
        checkOutput("d65_no_writes", writeCount, 32'd0);

        $display("[TB] request held for 20 cycles");
        applyStimulus(3, 70, 20, 0, 1'b0, 1'b0);
        checkOutput("hold_ctrl_cycles", ctrlCycles, 32'd21);
        checkOutput("hold_payload_bad", payloadBad, 32'd0);
        checkOutput("hold_early_recv", earlyRecv, 32'd0);
        checkOutput("hold_mem_bad", countMemBad(3), 32'd0);
        checkOutput("hold_done_err", {done, err}, 32'b10);

        $display("[TB] reset during third word, then N=2");
        applyStimulus(4, 100, 0, 3, 1'b0, 1'b0);
        checkOutput("abort_taken", {31'd0, aborted}, 32'd1);
        @(negedge clk);
        rst = 1'b1;
        applyStimulus(2, 60, 2, 0, 1'b0, 1'b0);
        checkOutput("after_abort_length", firstLength, 32'd8);
        checkOutput("after_abort_words", accepted, 32'd8);
        checkOutput("after_abort_mem_bad", countMemBad(2), 32'd0);
        checkOutput("after_abort_done_err", {done, err}, 32'b10);

        $display("[TB] start pulsed while receiving");
        applyStimulus(3, 80, 1, 0, 1'b1, 1'b0);
        checkOutput("poke_happened", {31'd0, poked}, 32'd1);
        checkOutput("poke_words", accepted, 32'd12);
        checkOutput("poke_requests", reqCount, 32'd1);
        checkOutput("poke_done_rises", doneRises, 32'd1);
        checkOutput("poke_mem_bad", countMemBad(3), 32'd0);
        checkOutput("poke_done_err", {done, err}, 32'b10);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
